// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-output programmable clock divider with lock and run-time reconfiguration
module clk_div_gen #(
  parameter int NUM_CLKS = 4,
  parameter int CNT_W = 16,
  parameter int LOCK_CYCLES = 64,
  parameter int DEFAULT_DIV = 4,
  localparam int CH_W = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic [CNT_W-1:0]    cfg_high,
  input  logic [CNT_W-1:0]    cfg_phase,
  output logic                cfg_err,
  output logic [NUM_CLKS-1:0] outclk,
  output logic                locked
);
  typedef enum logic {SETTLE, RUN} state_e;
  localparam int SW = $clog2(LOCK_CYCLES + 1);
  localparam logic [SW-1:0] LOCK_END = SW'(LOCK_CYCLES);
  localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CLKS);
  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEFAULT_DIV / 2);
  state_e state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] div_q [NUM_CLKS];
  logic [CNT_W-1:0] div_d [NUM_CLKS];
  logic [CNT_W-1:0] high_q [NUM_CLKS];
  logic [CNT_W-1:0] high_d [NUM_CLKS];
  logic [CNT_W-1:0] phase_q [NUM_CLKS];
  logic [CNT_W-1:0] phase_d [NUM_CLKS];
  logic [CNT_W-1:0] cnt_q [NUM_CLKS];
  logic [CNT_W-1:0] cnt_d [NUM_CLKS];
  logic [CNT_W-1:0] start [NUM_CLKS];
  logic [NUM_CLKS-1:0] outclk_q, outclk_d;
  logic cfg_err_q, cfg_err_d;
  logic hs, req_ok;
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= SETTLE;
      settle_q <= '0;
      div_q <= '{default: DEF_N};
      high_q <= '{default: DEF_H};
      phase_q <= '{default: '0};
      cnt_q <= '{default: '0};
      outclk_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      settle_q <= settle_d;
      div_q <= div_d;
      high_q <= high_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      outclk_q <= outclk_d;
      cfg_err_q <= cfg_err_d;
    end
  end
  // The accept edge counts as the first settle cycle, so a reconfig holds locked low LOCK_CYCLES cycles.
  always_comb begin
    hs = cfg_valid && state_q == RUN;
    req_ok = cfg_div > CNT_W'(1) && cfg_phase < cfg_div && {1'b0, cfg_chan} < NCH;
    cfg_err_d = hs && !req_ok;
    div_d = div_q;
    high_d = high_q;
    phase_d = phase_q;
    state_d = state_q;
    settle_d = settle_q;
    if (state_q == SETTLE) begin
      state_d = settle_q == LOCK_END ? RUN : SETTLE;
      settle_d = settle_q + 1'b1;
    end else if (hs && req_ok) begin
      div_d[cfg_chan] = cfg_div;
      high_d[cfg_chan] = cfg_high;
      phase_d[cfg_chan] = cfg_phase;
      state_d = SETTLE;
      settle_d = SW'(1);
    end
    for (int i = 0; i < NUM_CLKS; i++) begin
      start[i] = phase_q[i] == '0 ? '0 : div_q[i] - phase_q[i];
      cnt_d[i] = state_q == SETTLE ? start[i] : (cnt_q[i] == div_q[i] - CNT_W'(1) ? '0 : cnt_q[i] + CNT_W'(1));
      outclk_d[i] = state_d == RUN && cnt_d[i] < high_q[i];
    end
  end
  always_comb begin
    cfg_ready = state_q == RUN;
    locked = state_q == RUN;
    cfg_err = cfg_err_q;
    outclk = outclk_q;
  end
endmodule
